ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
- Next-generation EX→MEM pipeline register for the 32-bit core.
- Replaces a plain enable-gated latch with a valid/ready handshake, a 2-entry skid buffer, a synchronous flush and write-enable squashing on bubbles.
- Lets MEM back-pressure EX without a combinational ready path, and lets branch/exception logic kill in-flight instructions.

Parameters:
- DBITS, 32, width of ALU result / address.
- REG_INDEX_BIT_WIDTH, 4, destination register index width.
- OP_BITS, 4, opcode field width.
- FUNC_BITS, 4, function field width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  register can accept this cycle (registered, no combinational path from out_ready).
- op  in  OP_BITS  opcode from EX.
- func  in  FUNC_BITS  function code from EX.
- result  in  DBITS  ALU result from EX.
- rd  in  REG_INDEX_BIT_WIDTH  destination register.
- wrReg  in  1  register-write request from EX.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM accepts this cycle.
- ME_op  out  OP_BITS  held opcode.
- ME_func  out  FUNC_BITS  held function.
- ME_result  out  DBITS  held result.
- ME_rd  out  REG_INDEX_BIT_WIDTH  held destination.
- ME_wrReg  out  1  write request, forced 0 whenever out_valid=0.
- stall_cnt  out  16  back-pressure cycle counter (see Optional Feature).

Behaviour:
- Payload = {op, func, result, rd, wrReg}, two storage entries: main (drives ME_*) and skid.
- State machine, states EMPTY, ONE, TWO:
  - EMPTY: in_valid → ONE; payload loads into main.
  - ONE, in_valid & out_ready: stay ONE; main reloads with new payload.
  - ONE, in_valid & !out_ready: → TWO; payload loads into skid.
  - ONE, !in_valid & out_ready: → EMPTY.
  - ONE, otherwise: hold.
  - TWO, out_ready: → ONE; skid moves to main. Input is ignored because in_ready=0.
  - TWO, !out_ready: hold.
- Accept rule: a transfer happens when in_valid & in_ready; in_ready = (state != TWO), registered.
- Outputs:
  - out_valid = (state != EMPTY).
  - Data latency is 1 cycle: a beat accepted at edge N appears on ME_* after edge N.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Bubble squash:
  - ME_wrReg = main.wrReg & out_valid.
  - Other ME_* fields hold their last value when invalid; downstream must qualify them with out_valid.
- flush:
  - Next edge → EMPTY, both entries invalid, in_ready=1.
  - flush wins over a simultaneous in_valid (the beat is discarded) and over out_ready (nothing is accepted downstream that cycle).
  - Held ME_* data is not cleared.
- reset (asynchronous, any time, including mid-transfer or in TWO):
  - state=EMPTY, out_valid=0, in_ready=1.
  - ME_op=0, ME_func=0, ME_result=0, ME_rd=0, ME_wrReg=0, skid=0, stall_cnt=0.
- Widths are fixed per parameter; no arithmetic on the payload.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - Saturates at 16'hFFFF.
  - Clears on reset only; flush does not clear it.
- Undefined: stall_cnt is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package ex_mem_pkg:
  - State encoding typedef: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Localparam PAYLOAD_W = OP_BITS+FUNC_BITS+DBITS+REG_INDEX_BIT_WIDTH+1.
  - Payload pack/unpack field-offset constants.
- One sub-module, pipe_payload_reg:
  - Parametrised-width register with async reset and load enable.
  - Instantiated twice (main, skid).

Test Plan:
- Reset then single beat: reset=1 → all ME_*=0, in_ready=1. Then in_valid=1, op=4'h3, result=32'hDEADBEEF, rd=4'h5, wrReg=1, out_ready=1 → next cycle out_valid=1, ME_result=32'hDEADBEEF, ME_rd=5, ME_wrReg=1.
- Back-pressure/skid: out_ready=0, three back-to-back beats results 1, 2, 3 → beats 1 and 2 accepted, in_ready=0 after the second, beat 3 held by EX. Raise out_ready → outputs 1, 2, 3 in order, no loss.
- Streaming: in_valid=out_ready=1 for 10 cycles with results 0..9 → state stays ONE, one result per cycle, in_ready stays 1.
- Flush in TWO plus simultaneous input: flush=1, in_valid=1 with result 32'h77 → next cycle out_valid=0, ME_wrReg=0, in_ready=1, and 32'h77 never appears.
- Async reset mid-stall: in TWO, assert reset between clock edges → out_valid and ME_wrReg drop to 0 immediately without a clock edge.
- EX_MEM_STALL_CNT_EN defined: out_valid=1, out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF and holds. With the macro undefined → stall_cnt=0 throughout.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and payload layout helpers for the EX->MEM pipeline register.
// Optional stall counter is enabled with EX_MEM_STALL_CNT_EN.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int DBITS_DEF     = 32;
    localparam int REG_W_DEF     = 4;
    localparam int OP_BITS_DEF   = 4;
    localparam int FUNC_BITS_DEF = 4;

    // Payload packs as {op, func, result, rd, wrReg}, wrReg at bit 0.
    function automatic int payload_w(int ob, int fb, int db, int rb);
        return ob + fb + db + rb + 1;
    endfunction

    function automatic int rd_off();
        return 1;
    endfunction

    function automatic int res_off(int rb);
        return 1 + rb;
    endfunction

    function automatic int func_off(int rb, int db);
        return 1 + rb + db;
    endfunction

    function automatic int op_off(int rb, int db, int fb);
        return 1 + rb + db + fb;
    endfunction

    localparam int PAYLOAD_W =
        payload_w(OP_BITS_DEF, FUNC_BITS_DEF, DBITS_DEF, REG_W_DEF);

endpackage

// File: rtl/ex_mem_pipe_reg_payload.sv
// Load-enabled payload register with asynchronous active-high reset.
// Used for both the main and the skid entry of the EX->MEM register.
import ex_mem_pkg::*;

module pipe_payload_reg #(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: valid/ready handshake, 2-entry skid, flush.
// Define EX_MEM_STALL_CNT_EN to build the saturating back-pressure counter.
import ex_mem_pkg::*;

module ex_mem_pipe_reg #(
    parameter int DBITS               = DBITS_DEF,
    parameter int REG_INDEX_BIT_WIDTH = REG_W_DEF,
    parameter int OP_BITS             = OP_BITS_DEF,
    parameter int FUNC_BITS           = FUNC_BITS_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OP_BITS-1:0]             op,
    input  logic [FUNC_BITS-1:0]           func,
    input  logic [DBITS-1:0]               result,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rd,
    input  logic                           wrReg,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OP_BITS-1:0]             ME_op,
    output logic [FUNC_BITS-1:0]           ME_func,
    output logic [DBITS-1:0]               ME_result,
    output logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
    output logic                           ME_wrReg,
    output logic [15:0]                    stall_cnt
);

    localparam int RB = REG_INDEX_BIT_WIDTH;
    localparam int PW = payload_w(OP_BITS, FUNC_BITS, DBITS, RB);
    localparam int RD_O = rd_off();
    localparam int RES_O = res_off(RB);
    localparam int FUNC_O = func_off(RB, DBITS);
    localparam int OP_O = op_off(RB, DBITS, FUNC_BITS);

    state_e        state_q, state_d;
    logic          in_ready_q;
    logic          main_ld, skid_ld, from_skid;
    logic [PW-1:0] in_pl, main_d, main_q, skid_q;

    assign in_pl = {op, func, result, rd, wrReg};

    always_comb begin
        state_d   = state_q;
        main_ld   = 1'b0;
        skid_ld   = 1'b0;
        from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        state_d = ONE;
                        main_ld = 1'b1;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        main_ld = 1'b1;
                    end else if (in_valid) begin
                        state_d = TWO;
                        skid_ld = 1'b1;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        state_d   = ONE;
                        main_ld   = 1'b1;
                        from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_d = from_skid ? skid_q : in_pl;

    // in_ready comes from a flop so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk    (clk),
        .reset  (reset),
        .load_i (main_ld),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_ld),
        .d_i    (in_pl),
        .q_o    (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign ME_op     = main_q[OP_O +: OP_BITS];
    assign ME_func   = main_q[FUNC_O +: FUNC_BITS];
    assign ME_result = main_q[RES_O +: DBITS];
    assign ME_rd     = main_q[RD_O +: RB];
    assign ME_wrReg  = main_q[0] & out_valid;

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed, table-driven bench for ex_mem_pipe_reg.
// Counter saturation is exercised when EX_MEM_STALL_CNT_EN is defined.
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, wrReg;
    logic [3:0]  op, func, rd;
    logic [31:0] result;
    logic        out_valid, out_ready;
    logic [3:0]  ME_op, ME_func, ME_rd;
    logic [31:0] ME_result;
    logic        ME_wrReg;
    logic [15:0] stall_cnt;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = '0;
    logic        exp_ov_q = 1'b0;

    typedef struct {
        logic        fl, iv, ordy;
        logic [31:0] res;
        logic        wr;
        logic        ov, ir;
        logic [31:0] eres;
        logic        ewr;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .func      (func),
        .result    (result),
        .rd        (rd),
        .wrReg     (wrReg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ME_op     (ME_op),
        .ME_func   (ME_func),
        .ME_result (ME_result),
        .ME_rd     (ME_rd),
        .ME_wrReg  (ME_wrReg),
        .stall_cnt (stall_cnt)
    );

    function automatic vec_t mk(logic fl, logic iv, logic ordy,
                                logic [31:0] res, logic wr,
                                logic ov, logic ir,
                                logic [31:0] eres, logic ewr);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy;
        v.res = res; v.wr = wr;
        v.ov = ov; v.ir = ir;
        v.eres = eres; v.ewr = ewr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // op/func/rd are derived from result so one number identifies a beat.
    task automatic step(input logic f, input logic iv, input logic ordy,
                        input logic [31:0] r, input logic w);
        flush = f; in_valid = iv; out_ready = ordy;
        result = r; wrReg = w;
        op = r[3:0] ^ 4'hC; func = r[7:4]; rd = r[3:0] ^ 4'hA;
        @(posedge clk);
`ifdef EX_MEM_STALL_CNT_EN
        if (exp_ov_q && !ordy && exp_cnt != 16'hFFFF)
            exp_cnt = exp_cnt + 16'd1;
`endif
        #1;
    endtask

    task automatic check_all(input string tag, input logic ov,
                             input logic ir, input logic [31:0] eres,
                             input logic ewr);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, ".ME_result"}, ME_result, eres);
        chk({tag, ".ME_op"}, 32'(ME_op), 32'(eres[3:0] ^ 4'hC));
        chk({tag, ".ME_func"}, 32'(ME_func), 32'(eres[7:4]));
        chk({tag, ".ME_rd"}, 32'(ME_rd), 32'(eres[3:0] ^ 4'hA));
        chk({tag, ".ME_wrReg"}, 32'(ME_wrReg), 32'(ewr));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".ME_result"}, ME_result, 32'd0);
        chk({tag, ".ME_op"}, 32'(ME_op), 32'd0);
        chk({tag, ".ME_func"}, 32'(ME_func), 32'd0);
        chk({tag, ".ME_rd"}, 32'(ME_rd), 32'd0);
        chk({tag, ".ME_wrReg"}, 32'(ME_wrReg), 32'd0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; func = '0; rd = '0; result = '0; wrReg = 1'b0;

        // drain, back-pressure into skid, beat 3 held by EX, drain again
        tbl.push_back(mk(0,0,1, 32'h0, 0,  0,1, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0,1,0, 32'h1, 1,  1,1, 32'h1, 1));
        tbl.push_back(mk(0,1,0, 32'h2, 1,  1,0, 32'h1, 1));
        tbl.push_back(mk(0,1,0, 32'h3, 1,  1,0, 32'h1, 1));
        tbl.push_back(mk(0,1,1, 32'h3, 1,  1,1, 32'h2, 1));
        tbl.push_back(mk(0,1,1, 32'h3, 1,  1,1, 32'h3, 1));
        tbl.push_back(mk(0,0,1, 32'h0, 0,  0,1, 32'h3, 0));
        // streaming 0..9
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0,1,1, 32'(k), k[0], 1,1, 32'(k), k[0]));
        // fill skid, then flush in TWO with a simultaneous beat
        tbl.push_back(mk(0,1,0, 32'h10, 1, 1,0, 32'h9, 1));
        tbl.push_back(mk(0,0,0, 32'h0, 0,  1,0, 32'h9, 1));
        tbl.push_back(mk(1,1,1, 32'h77, 1, 0,1, 32'h9, 0));
        tbl.push_back(mk(0,0,1, 32'h0, 0,  0,1, 32'h9, 0));
        tbl.push_back(mk(0,1,1, 32'h20, 1, 1,1, 32'h20, 1));
        tbl.push_back(mk(1,0,0, 32'h0, 0,  0,1, 32'h20, 0));
        tbl.push_back(mk(0,1,0, 32'h30, 0, 1,1, 32'h30, 0));
        tbl.push_back(mk(0,0,0, 32'h0, 0,  1,1, 32'h30, 0));
        tbl.push_back(mk(0,0,1, 32'h0, 0,  0,1, 32'h30, 0));
        // flush in EMPTY beats an acceptable in_valid
        tbl.push_back(mk(1,1,1, 32'h44, 1, 0,1, 32'h30, 0));

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        reset = 1'b0;

        step(0, 1, 1, 32'hDEADBEEF, 1);
        check_all("beat1", 1, 1, 32'hDEADBEEF, 1);
        chk("beat1.op3", 32'(ME_op), 32'h3);
        chk("beat1.rd5", 32'(ME_rd), 32'h5);
        exp_ov_q = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].res, tbl[i].wr);
            check_all($sformatf("row%0d", i), tbl[i].ov, tbl[i].ir,
                      tbl[i].eres, tbl[i].ewr);
            exp_ov_q = tbl[i].ov;
        end

        // async reset while in TWO, between clock edges
        step(0, 1, 0, 32'h50, 1);
        check_all("ms1", 1, 1, 32'h50, 1);
        exp_ov_q = 1'b1;
        step(0, 1, 0, 32'h51, 1);
        check_all("ms2", 1, 0, 32'h50, 1);
        #3 reset = 1'b1;
        #1;
        exp_cnt = '0;
        exp_ov_q = 1'b0;
        check_reset("async_rst");
        #2 reset = 1'b0;
        step(0, 1, 1, 32'h60, 1);
        check_all("post_rst", 1, 1, 32'h60, 1);
        exp_ov_q = 1'b1;

`ifdef EX_MEM_STALL_CNT_EN
        for (int n = 0; n < 70000; n++)
            step(0, 0, 0, 32'h0, 0);
        check_all("sat", 1, 1, 32'h60, 1);
        chk("sat.ffff", 32'(stall_cnt), 32'hFFFF);
        repeat (5) step(0, 0, 0, 32'h0, 0);
        chk("sat.hold", 32'(stall_cnt), 32'hFFFF);
        step(1, 0, 0, 32'h0, 0);
        chk("sat.flush", 32'(stall_cnt), 32'hFFFF);
`else
        for (int n = 0; n < 20; n++)
            step(0, 0, 0, 32'h0, 0);
        check_all("nocnt", 1, 1, 32'h60, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
